jtag_host: RTL

Host-side JTAG driver that generates TCK/TMS/TDI from the system clock and samples TDO to drive an external TAP through reset, IR-scan, DR-scan and run-test sequences. It sits in the sys_clk domain next to the test/debug logic and lets on-chip firmware or a bench issue HALT/STEP/RESUME, IDCODE and boundary-scan operations. The block tracks the target TAP state internally, so commands are issued as whole scans rather than as raw TMS bits.

---
 rtl/jtag_host.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/jtag_host.sv
// Host-side JTAG driver: turns whole-scan commands (reset, IR/DR scan, run-test)
// into TCK/TMS/TDI bit sequences while tracking the target TAP state.
module jtag_host #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32,
  localparam int LW = $clog2(MAX_LEN)
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LW-1:0]      cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  output logic               trst,
  input  logic               tdo
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HI_START = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CAP_AT   = CW'(CLK_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(2 * CLK_DIV - 1);
  localparam logic [LW:0]   ONE      = (LW + 1)'(1);

  localparam logic [1:0] C_RESET = 2'b00;
  localparam logic [1:0] C_IR    = 2'b01;
  localparam logic [1:0] C_DR    = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_SHIFT, S_SUFFIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LW:0]        rem_q, rem_d;
  logic [LW-1:0]      sidx_q, sidx_d;
  logic [4:0]         pat_q, pat_d;
  logic [1:0]         type_q, type_d;
  logic [LW-1:0]      len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               tlr_q, tlr_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               trst_q, trst_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               new_bit;
  logic               finish;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    sidx_d      = sidx_q;
    pat_d       = pat_q;
    type_d      = type_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    rsp_data_d  = rsp_data_q;
    tlr_d       = tlr_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trst_d      = trst_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    new_bit     = 1'b0;
    finish      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        trst_d  = 1'b1;
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          type_d  = cmd_type;
          len_d   = cmd_len;
          data_d  = cmd_data;
          cap_d   = '0;
          sidx_d  = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = S_PREFIX;
          new_bit = 1'b1;
          case (cmd_type)
            C_RESET: begin pat_d = 5'b11111; rem_d = (LW + 1)'(5); trst_d = 1'b0; tlr_d = 1'b1; end
            C_IR:    begin pat_d = 5'b00011; rem_d = (LW + 1)'(4); end
            C_DR:    begin pat_d = 5'b00001; rem_d = (LW + 1)'(3); end
            default: begin pat_d = 5'b00000; rem_d = {1'b0, cmd_len} + ONE; end
          endcase
          // Leaving Test-Logic-Reset costs one TMS=0 bit before the normal walk.
          if (cmd_type != C_RESET && tlr_q) begin
            pat_d = {pat_d[3:0], 1'b0};
            rem_d = rem_d + ONE;
            tlr_d = 1'b0;
          end
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HI_START) tck_d = 1'b1;
        if (state_q == S_SHIFT && cnt_q == CAP_AT) cap_d[sidx_q] = tdo;
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          tck_d = 1'b0;
          if (rem_q > ONE) begin
            rem_d   = rem_q - ONE;
            pat_d   = pat_q >> 1;
            new_bit = 1'b1;
            if (state_q == S_SHIFT) sidx_d = sidx_q + 1'b1;
          end else begin
            case (state_q)
              S_PREFIX: begin
                if (type_q == C_IR || type_q == C_DR) begin
                  state_d = S_SHIFT;
                  rem_d   = {1'b0, len_q} + ONE;
                  new_bit = 1'b1;
                end else begin
                  finish = 1'b1;
                end
              end
              S_SHIFT: begin
                state_d = S_SUFFIX;
                rem_d   = (LW + 1)'(2);
                pat_d   = 5'b00001;
                new_bit = 1'b1;
              end
              default: finish = 1'b1;
            endcase
          end
          if (finish) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            ready_d     = 1'b1;
            trst_d      = 1'b1;
            rsp_data_d  = cap_q;
          end
        end
      end
    endcase

    // TMS/TDI only move at bit boundaries, which always coincide with tck low.
    if (new_bit) begin
      tms_d = (state_d == S_SHIFT) ? (rem_d == ONE) : pat_d[0];
      tdi_d = (state_d == S_SHIFT) ? data_d[sidx_d] : 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      sidx_q      <= '0;
      pat_q       <= '0;
      type_q      <= '0;
      len_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      tlr_q       <= 1'b1;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_q      <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      sidx_q      <= sidx_d;
      pat_q       <= pat_d;
      type_q      <= type_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      tlr_q       <= tlr_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_q      <= trst_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign trst      = trst_q;

endmodule
